// File: rtl/reverse_radix_if.sv
// Request/result bundle for the digit-reversal engine.
interface reverse_radix_if #(
    parameter int WIDTH = 16,
    parameter int DW    = $clog2(WIDTH + 1)
) ();
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] reverse;
    logic [DW-1:0]    digits;
    logic             palin;
    logic             ovf;
    logic             busy;
    logic             Done;

    modport master (
        output start, mode, x,
        input  reverse, digits, palin, ovf, busy, Done
    );

    modport slave (
        input  start, mode, x,
        output reverse, digits, palin, ovf, busy, Done
    );
endinterface

// File: rtl/reverse_radix.sv
// Iterative digit reversal of an unsigned operand in radix 10, 2, 8 or 16.
// One digit is peeled off per cycle; results are published on entry to DONE.
module reverse_radix #(
    parameter int WIDTH = 16,
    parameter int DW    = $clog2(WIDTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    reverse_radix_if.slave bus
);
    // Four guard bits: a reversed value can exceed the operand width.
    localparam int AW = WIDTH + 4;
    localparam logic [WIDTH-1:0] TEN = WIDTH'(10);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] xq_q,      xq_d;
    logic [WIDTH-1:0] work_q,    work_d;
    logic [AW-1:0]    acc_q,     acc_d;
    logic [DW-1:0]    cnt_q,     cnt_d;
    logic [1:0]       mode_q,    mode_d;
    logic [WIDTH-1:0] reverse_q, reverse_d;
    logic [DW-1:0]    digits_q,  digits_d;
    logic             palin_q,   palin_d;
    logic             ovf_q,     ovf_d;

    logic [WIDTH-1:0] quot;
    logic [3:0]       dig;
    logic [AW-1:0]    acc_mul;

    // Per-radix quotient, low digit and acc*R; only radix 10 needs a real divide.
    always_comb begin
        quot    = work_q;
        dig     = '0;
        acc_mul = acc_q;
        case (mode_q)
            2'b01: begin
                quot    = work_q >> 1;
                dig     = {3'b000, work_q[0]};
                acc_mul = acc_q << 1;
            end
            2'b10: begin
                quot    = work_q >> 3;
                dig     = {1'b0, work_q[2:0]};
                acc_mul = acc_q << 3;
            end
            2'b11: begin
                quot    = work_q >> 4;
                dig     = work_q[3:0];
                acc_mul = acc_q << 4;
            end
            default: begin
                quot    = work_q / TEN;
                dig     = 4'(work_q - quot * TEN);
                acc_mul = (acc_q << 3) + (acc_q << 1);
            end
        endcase
    end

    // Next-state and result computation; everything holds unless told otherwise.
    always_comb begin
        state_d   = state_q;
        xq_d      = xq_q;
        work_d    = work_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        reverse_d = reverse_q;
        digits_d  = digits_q;
        palin_d   = palin_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    xq_d    = bus.x;
                    work_d  = bus.x;
                    mode_d  = bus.mode;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (work_q != '0) begin
                    acc_d  = acc_mul + AW'(dig);
                    work_d = quot;
                    cnt_d  = cnt_q + DW'(1);
                end else begin
                    state_d   = DONE;
                    reverse_d = acc_q[WIDTH-1:0];
                    ovf_d     = (acc_q[AW-1:WIDTH] != '0);
                    digits_d  = (cnt_q == '0) ? DW'(1) : cnt_q;
                    palin_d   = (acc_q == {4'b0000, xq_q}) && (acc_q[AW-1:WIDTH] == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            xq_q      <= '0;
            work_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= '0;
            reverse_q <= '0;
            digits_q  <= '0;
            palin_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            xq_q      <= xq_d;
            work_q    <= work_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            reverse_q <= reverse_d;
            digits_q  <= digits_d;
            palin_q   <= palin_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.reverse = reverse_q;
    assign bus.digits  = digits_q;
    assign bus.palin   = palin_q;
    assign bus.ovf     = ovf_q;
    assign bus.busy    = (state_q == RUN);
    assign bus.Done    = (state_q == DONE);
endmodule

// File: tb/tb_reverse_radix.sv
// Directed bench for reverse_radix at WIDTH=16.
module tb_reverse_radix;
    localparam int WIDTH = 16;
    localparam int DW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    reverse_radix_if #(.WIDTH(WIDTH), .DW(DW)) bus ();

    reverse_radix #(.WIDTH(WIDTH), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Pulse start for one edge and count edges until Done (bounded at 100).
    task automatic run(input logic [1:0] m, input logic [15:0] v,
                       output int edges, output int busy_cnt);
        bus.mode  = m;
        bus.x     = v;
        bus.start = 1'b1;
        edges     = 0;
        busy_cnt  = 0;
        while (edges < 100) begin
            @(posedge clk); #1;
            edges++;
            bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.Done) break;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        int e, b;
        bus.start = 1'b0; bus.mode = 2'b00; bus.x = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.reverse, bus.digits, bus.palin, bus.ovf, bus.busy, bus.Done} !== '0) begin
            $display("FAIL reset_outputs: got rev=%0d dig=%0d pal=%0b ovf=%0b busy=%0b done=%0b required all 0",
                     bus.reverse, bus.digits, bus.palin, bus.ovf, bus.busy, bus.Done);
            errors++;
        end
        // First start accepted on the very first edge with rst low.
        rst = 1'b0; bus.x = 16'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            $display("FAIL first_start_busy: got %0b required 1", bus.busy);
            errors++;
        end
        e = 1; b = 0;
        while (!bus.Done && e < 100) begin @(posedge clk); #1; e++; end
        checks++;
        if (bus.reverse !== 16'd7 || bus.digits !== 5'd1 || bus.palin !== 1'b1) begin
            $display("FAIL first_start_result: got rev=%0d dig=%0d pal=%0b required 7 1 1",
                     bus.reverse, bus.digits, bus.palin);
            errors++;
        end
    endtask

    task automatic test_decimal();
        int e, b;
        run(2'b00, 16'd1234, e, b);
        checks++;
        if (e !== 6 || b !== 5) begin
            $display("FAIL dec1234_latency: got edges=%0d busy=%0d required 6 5", e, b);
            errors++;
        end
        checks++;
        if (bus.reverse !== 16'd4321 || bus.digits !== 5'd4 || bus.palin !== 1'b0 || bus.ovf !== 1'b0) begin
            $display("FAIL dec1234_result: got rev=%0d dig=%0d pal=%0b ovf=%0b required 4321 4 0 0",
                     bus.reverse, bus.digits, bus.palin, bus.ovf);
            errors++;
        end
        // Results hold while idle in DONE with start low.
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.Done !== 1'b1 || bus.reverse !== 16'd4321 || bus.digits !== 5'd4) begin
            $display("FAIL done_hold: got done=%0b rev=%0d dig=%0d required 1 4321 4",
                     bus.Done, bus.reverse, bus.digits);
            errors++;
        end
        run(2'b00, 16'd120, e, b);
        checks++;
        if (bus.reverse !== 16'd21 || bus.digits !== 5'd3 || bus.palin !== 1'b0) begin
            $display("FAIL dec120_trailing: got rev=%0d dig=%0d pal=%0b required 21 3 0",
                     bus.reverse, bus.digits, bus.palin);
            errors++;
        end
    endtask

    task automatic test_overflow();
        int e, b;
        run(2'b00, 16'd19999, e, b);
        checks++;
        if (bus.reverse !== 16'd34455 || bus.ovf !== 1'b1 || bus.digits !== 5'd5 || bus.palin !== 1'b0) begin
            $display("FAIL dec19999_ovf: got rev=%0d ovf=%0b dig=%0d pal=%0b required 34455 1 5 0",
                     bus.reverse, bus.ovf, bus.digits, bus.palin);
            errors++;
        end
    endtask

    task automatic test_radices();
        int e, b;
        run(2'b11, 16'h1A2B, e, b);
        checks++;
        if (bus.reverse !== 16'hB2A1 || bus.digits !== 5'd4 || bus.ovf !== 1'b0) begin
            $display("FAIL hex1A2B: got rev=%0h dig=%0d ovf=%0b required b2a1 4 0",
                     bus.reverse, bus.digits, bus.ovf);
            errors++;
        end
        run(2'b01, 16'h000B, e, b);
        checks++;
        if (bus.reverse !== 16'h000D || bus.digits !== 5'd4 || e !== 6) begin
            $display("FAIL bin1011: got rev=%0h dig=%0d edges=%0d required d 4 6",
                     bus.reverse, bus.digits, e);
            errors++;
        end
        run(2'b10, 16'o17, e, b);
        checks++;
        if (bus.reverse !== 16'o71 || bus.digits !== 5'd2 || bus.palin !== 1'b0) begin
            $display("FAIL oct17: got rev=%0o dig=%0d pal=%0b required 71 2 0",
                     bus.reverse, bus.digits, bus.palin);
            errors++;
        end
    endtask

    task automatic test_palindrome();
        int e, b;
        run(2'b00, 16'd12321, e, b);
        checks++;
        if (bus.reverse !== 16'd12321 || bus.palin !== 1'b1 || bus.digits !== 5'd5) begin
            $display("FAIL dec12321_palin: got rev=%0d pal=%0b dig=%0d required 12321 1 5",
                     bus.reverse, bus.palin, bus.digits);
            errors++;
        end
        run(2'b00, 16'd0, e, b);
        checks++;
        if (e !== 2 || bus.reverse !== 16'd0 || bus.digits !== 5'd1 || bus.palin !== 1'b1) begin
            $display("FAIL zero_operand: got edges=%0d rev=%0d dig=%0d pal=%0b required 2 0 1 1",
                     e, bus.reverse, bus.digits, bus.palin);
            errors++;
        end
    endtask

    task automatic test_start_ignored();
        int e, b;
        bus.mode = 2'b00; bus.x = 16'd1234; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.x = 16'd5555; bus.mode = 2'b11; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        e = 3;
        while (!bus.Done && e < 100) begin @(posedge clk); #1; e++; end
        checks++;
        if (e !== 6 || bus.reverse !== 16'd4321 || bus.digits !== 5'd4) begin
            $display("FAIL start_in_run: got edges=%0d rev=%0d dig=%0d required 6 4321 4",
                     e, bus.reverse, bus.digits);
            errors++;
        end
        // Restart from DONE: Done drops at once, old result held during RUN.
        bus.mode = 2'b00; bus.x = 16'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.Done !== 1'b0 || bus.busy !== 1'b1 || bus.reverse !== 16'd4321) begin
            $display("FAIL restart_from_done: got done=%0b busy=%0b rev=%0d required 0 1 4321",
                     bus.Done, bus.busy, bus.reverse);
            errors++;
        end
        e = 1;
        while (!bus.Done && e < 100) begin @(posedge clk); #1; e++; end
        checks++;
        if (bus.reverse !== 16'd7 || bus.digits !== 5'd1 || e !== 3) begin
            $display("FAIL restart_result: got rev=%0d dig=%0d edges=%0d required 7 1 3",
                     bus.reverse, bus.digits, e);
            errors++;
        end
    endtask

    task automatic test_reset_mid_run();
        int e, b;
        int done_seen;
        bus.mode = 2'b00; bus.x = 16'd1234; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({bus.reverse, bus.digits, bus.palin, bus.ovf, bus.busy, bus.Done} !== '0) begin
            $display("FAIL reset_mid_run: got rev=%0d dig=%0d pal=%0b ovf=%0b busy=%0b done=%0b required all 0",
                     bus.reverse, bus.digits, bus.palin, bus.ovf, bus.busy, bus.Done);
            errors++;
        end
        done_seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.Done || bus.busy) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            $display("FAIL reset_abort_quiet: got %0d active cycles required 0", done_seen);
            errors++;
        end
        run(2'b00, 16'd1234, e, b);
        checks++;
        if (e !== 6 || bus.reverse !== 16'd4321 || bus.digits !== 5'd4) begin
            $display("FAIL run_after_reset: got edges=%0d rev=%0d dig=%0d required 6 4321 4",
                     e, bus.reverse, bus.digits);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_decimal();
        test_overflow();
        test_radices();
        test_palindrome();
        test_start_ignored();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reverse_radix.md
REVERSE_RADIX -- requirements
Module: reverse_radix

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits; legal range 4..32.
REQ-002 Parameter: DW, default $clog2(WIDTH+1), digit-count output width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  request a new reversal; sampled only in IDLE or DONE.
REQ-006 Port: mode  input  2  radix select, sampled with start: 00 = 10, 01 = 2, 10 = 8, 11 = 16.
REQ-007 Port: x  input  WIDTH  unsigned operand, sampled with start.
REQ-008 Port: reverse  output  WIDTH  digit-reversed result, registered.
REQ-009 Port: digits  output  DW  number of radix digits in x, registered.
REQ-010 Port: palin  output  1  x is a palindrome in the selected radix, registered.
REQ-011 Port: ovf  output  1  full reversed value exceeds 2^WIDTH-1, registered.
REQ-012 Port: busy  output  1  high in RUN state.
REQ-013 Port: Done  output  1  high in DONE state; results valid while high.

Function
REQ-014 FSM states IDLE, RUN, DONE; busy = (state==RUN), Done = (state==DONE).
REQ-015 IDLE/DONE with start=1: latch x into xq and work, latch radix R from mode, clear acc (WIDTH+4 bits) and cnt, go to RUN; Done drops next cycle.
REQ-016 IDLE/DONE with start=0: hold state and all outputs.
REQ-017 RUN with work != 0: acc <= acc*R + (work mod R); work <= work / R; cnt <= cnt+1; stay in RUN.
REQ-018 RUN with work == 0: go to DONE; reverse <= acc[WIDTH-1:0]; ovf <= (acc[WIDTH+3:WIDTH] != 0); digits <= cnt, or 1 when cnt==0; palin <= (acc == zero-extended xq) and not ovf.
REQ-019 start while in RUN is ignored; mode and x changes in RUN have no effect.
REQ-020 Latency: x with D digits (D>=1) -> Done high on the (D+2)th rising edge after the edge sampling start; x=0 -> Done on the 2nd edge.
REQ-021 acc width WIDTH+4 is sufficient for all radices; no intermediate truncation.
REQ-022 Trailing zeros of x vanish from the result (radix 10, x=120 -> 21, palin=0).
REQ-023 reverse, digits, palin and ovf change only on entry to DONE or on reset; they hold the previous result through RUN.
REQ-024 Radix 2/8/16 division and modulo use shifts/masks; radix 10 may use combinational divide-by-constant.

Reset
REQ-025 rst=1 at a rising edge: state <= IDLE; reverse, digits, palin, ovf, busy, Done, acc, work, cnt, xq all <= 0.
REQ-026 rst has priority over start and over any RUN iteration; reset mid-operation aborts with no Done pulse.
REQ-027 First start is accepted on the first edge with rst=0.

Verification (WIDTH=16)
REQ-028 mode=00, x=1234, start one cycle -> busy for 5 cycles, Done on 6th edge, reverse=4321, digits=4, palin=0, ovf=0.
REQ-029 mode=00, x=19999 -> reverse=34455 (99991 mod 65536), ovf=1, digits=5, palin=0.
REQ-030 mode=11, x=0x1A2B -> reverse=0xB2A1, digits=4; mode=01, x=0x000B -> reverse=0x000D, digits=4; mode=10, x=0o17 -> reverse=0o71.
REQ-031 mode=00, x=12321 -> palin=1, reverse=12321; x=0 -> reverse=0, digits=1, palin=1, Done on 2nd edge.
REQ-032 start pulsed with x=5555 mid-RUN of x=1234 -> ignored, result 4321; then start from DONE with x=7 -> Done low next cycle, result 7.
REQ-033 rst asserted during RUN -> next cycle all outputs 0, state IDLE, no Done; subsequent start runs normally.
